// File: rtl/ifetch_unit.sv
// Instruction fetch: one outstanding imem read, result held for decode with valid/ready.
// Latency: accept->imem_req 1 cycle, imem_ack->instr_valid 1 cycle; decode backpressure holds the PC via pc_stall.
module ifetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic        pc_valid,
    input  logic        flush,
    output logic        pc_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        misalign,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

    state_t      state_q;
    logic        imem_req_q;
    logic [31:0] imem_addr_q;
    logic [31:0] instr_out_q;
    logic [31:0] instr_pc_q;
    logic        instr_valid_q;
    logic        misalign_q;
    logic [15:0] fetch_count_q;

    logic can_take;
    logic pc_aligned;
    logic accept;
    logic bad_pc;

    // A new PC can only be taken when nothing is in flight and the held slot is free or draining now.
    assign can_take   = (state_q == IDLE) || ((state_q == HOLD) && instr_ready);
    assign pc_aligned = (pc_in[1:0] == 2'b00);
    assign accept     = can_take && pc_valid && !flush && pc_aligned;
    assign bad_pc     = can_take && pc_valid && !flush && !pc_aligned;
    assign pc_stall   = !can_take;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= 32'h0;
            instr_out_q   <= 32'h0;
            instr_pc_q    <= 32'h0;
            instr_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
            fetch_count_q <= 16'h0;
        end else begin
            if (bad_pc) begin
                misalign_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= pc_in;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        imem_req_q <= 1'b0;
                        if (flush) begin
                            state_q <= IDLE;
                        end else begin
                            instr_out_q   <= imem_rdata;
                            instr_pc_q    <= imem_addr_q;
                            instr_valid_q <= 1'b1;
                            state_q       <= HOLD;
                        end
                    end else if (flush) begin
                        // The request cannot be withdrawn; wait out its ack and discard it.
                        state_q <= DROP;
                    end
                end
                HOLD: begin
                    if (flush) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= IDLE;
                    end else if (instr_ready) begin
                        fetch_count_q <= fetch_count_q + 16'd1;
                        instr_valid_q <= 1'b0;
                        if (accept) begin
                            imem_req_q  <= 1'b1;
                            imem_addr_q <= pc_in;
                            state_q     <= REQ;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        imem_req_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign instr_out   = instr_out_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign misalign    = misalign_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit; delivered instructions are checked by a scoreboard monitor.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        flush;
    logic        pc_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        misalign;
    logic [15:0] fetch_count;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] sb_q[$];
    logic [31:0] b2b_data [3] = '{32'h00000013, 32'h00100093, 32'h00208113};

    always #5 clk = ~clk;

    ifetch_unit dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid), .flush(flush),
        .pc_stall(pc_stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_out(instr_out),
        .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .misalign(misalign), .fetch_count(fetch_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    endtask

    // Monitor: each new instruction presented to decode must match the next scoreboard entry.
    initial begin
        logic prev_v;
        logic [63:0] exp;
        prev_v = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (instr_valid && !prev_v) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_instr", {instr_pc, instr_out}, 64'h0);
                end else begin
                    exp = sb_q.pop_front();
                    chk("sb_instr", {instr_pc, instr_out}, exp);
                end
            end
            prev_v = instr_valid;
        end
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: got timeout expected finish");
        summary();
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pc_in = 32'h0; pc_valid = 1'b0; flush = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
        #2;
        chk("rst_imem_req", imem_req, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_instr_out", instr_out, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_misalign", misalign, 0);
        chk("rst_fetch_count", fetch_count, 0);
        chk("rst_pc_stall", pc_stall, 0);

        // Single fetch, accepted on the first edge after reset release, ack two cycles after req.
        step(); rst = 1'b0; pc_in = 32'h10; pc_valid = 1'b1; instr_ready = 1'b1;
        sb_q.push_back({32'h10, 32'h8C220004});
        step(); pc_valid = 1'b0;
        chk("t1_req", imem_req, 1);
        chk("t1_addr", imem_addr, 32'h10);
        chk("t1_stall_req", pc_stall, 1);
        step(); chk("t1_req_stable", imem_req, 1);
        imem_ack = 1'b1; imem_rdata = 32'h8C220004;
        step(); imem_ack = 1'b0; imem_rdata = 32'h0;
        chk("t1_valid", instr_valid, 1);
        chk("t1_req_drop", imem_req, 0);
        chk("t1_count_before", fetch_count, 0);
        chk("t1_stall_hold_rdy", pc_stall, 0);
        step();
        chk("t1_count_after", fetch_count, 1);
        chk("t1_valid_clr", instr_valid, 0);

        // Back-to-back chaining HOLD -> REQ with ack in the cycle after req.
        for (int i = 0; i < 3; i++) begin
            step(); imem_ack = 1'b0; pc_in = 32'(4 * i); pc_valid = 1'b1;
            chk("b2b_stall_lo", pc_stall, 0);
            sb_q.push_back({32'(4 * i), b2b_data[i]});
            step(); pc_valid = 1'b0; imem_ack = 1'b1; imem_rdata = b2b_data[i];
            chk("b2b_stall_hi", pc_stall, 1);
            chk("b2b_addr", imem_addr, 32'(4 * i));
        end
        step(); imem_ack = 1'b0;
        chk("b2b_last_stall_lo", pc_stall, 0);
        step();
        chk("b2b_count", fetch_count, 4);

        // Flush while REQ waits for ack: request held through DROP, data discarded.
        pc_in = 32'h20; pc_valid = 1'b1;
        step(); pc_valid = 1'b0; flush = 1'b1;
        chk("fl_req", imem_req, 1);
        step(); flush = 1'b0;
        chk("fl_drop_req", imem_req, 1);
        chk("fl_drop_stall", pc_stall, 1);
        step(); flush = 1'b1;
        chk("fl_drop_req2", imem_req, 1);
        step(); flush = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
        step(); imem_ack = 1'b0;
        chk("fl_req_clr", imem_req, 0);
        chk("fl_no_valid", instr_valid, 0);
        chk("fl_idle_stall", pc_stall, 0);
        // Stray ack in IDLE must be ignored.
        imem_ack = 1'b1; imem_rdata = 32'h0BADF00D;
        step(); imem_ack = 1'b0;
        chk("idle_ack_valid", instr_valid, 0);
        chk("idle_ack_req", imem_req, 0);
        pc_in = 32'h40; pc_valid = 1'b1;
        sb_q.push_back({32'h40, 32'h00400093});
        step(); pc_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h00400093;
        chk("fl_next_addr", imem_addr, 32'h40);
        step(); imem_ack = 1'b0;
        chk("fl_next_valid", instr_valid, 1);
        step();
        chk("fl_next_count", fetch_count, 5);

        // Decode stalls five cycles in HOLD, then a flush kills the held instruction.
        instr_ready = 1'b0; pc_in = 32'h80; pc_valid = 1'b1;
        sb_q.push_back({32'h80, 32'h12345678});
        step(); pc_in = 32'h84; imem_ack = 1'b1; imem_rdata = 32'h12345678;
        step(); imem_ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("hold_instr", {instr_pc, instr_out}, {32'h80, 32'h12345678});
            chk("hold_valid", instr_valid, 1);
            chk("hold_stall", pc_stall, 1);
            step();
        end
        flush = 1'b1;
        step(); flush = 1'b0; pc_valid = 1'b0;
        chk("hold_flush_valid", instr_valid, 0);
        chk("hold_flush_count", fetch_count, 5);
        chk("hold_flush_noreq", imem_req, 0);
        instr_ready = 1'b1;

        // Misaligned PC: no request, sticky flag, cleared only by reset.
        pc_in = 32'h6; pc_valid = 1'b1;
        step(); pc_valid = 1'b0;
        chk("mis_noreq", imem_req, 0);
        chk("mis_flag", misalign, 1);
        step();
        chk("mis_sticky", misalign, 1);
        rst = 1'b1;
        #1;
        chk("mis_rst_clr", misalign, 0);
        step(); rst = 1'b0;

        // Counter wrap from 0xFFFF.
        force dut.fetch_count_q = 16'hFFFF;
        #1;
        release dut.fetch_count_q;
        chk("wrap_preload", fetch_count, 16'hFFFF);
        pc_in = 32'hC0; pc_valid = 1'b1;
        sb_q.push_back({32'hC0, 32'hCAFEF00D});
        step(); pc_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hCAFEF00D;
        step(); imem_ack = 1'b0;
        step();
        chk("wrap_count", fetch_count, 16'h0000);

        // Reset mid-REQ abandons the request; late ack afterwards is ignored.
        pc_in = 32'h100; pc_valid = 1'b1;
        step(); pc_valid = 1'b0;
        chk("rreq_req", imem_req, 1);
        rst = 1'b1;
        #1;
        chk("rreq_req_clr", imem_req, 0);
        step(); rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h11111111;
        step(); imem_ack = 1'b0;
        chk("late_ack_valid", instr_valid, 0);
        chk("late_ack_req", imem_req, 0);
        chk("late_ack_idle", pc_stall, 0);

        step(); step();
        chk("sb_empty", sb_q.size(), 0);
        summary();
        $finish;
    end

endmodule
